// File: rtl/axis_msg_cnt_pkg.sv
// Shared record type and saturating arithmetic helpers for the AXI4-Stream
// message length counter.
package axis_msg_cnt_pkg;

  localparam int unsigned LEN_CNT_W  = 16;
  localparam int unsigned LEN_CHAN_W = 2;
  localparam int unsigned CALC_W     = 32;
  localparam int unsigned KEEP_MAX_W = 64;

  typedef struct packed {
    logic [LEN_CNT_W-1:0]  bytes;
    logic [LEN_CNT_W-1:0]  beats;
    logic [LEN_CHAN_W-1:0] chan;
    logic                  sat;
  } len_rec_t;

  function automatic logic [CALC_W-1:0] popcount(input logic [KEEP_MAX_W-1:0] keep);
    logic [CALC_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < KEEP_MAX_W; i++) begin
      n = n + {{(CALC_W-1){1'b0}}, keep[i]};
    end
    return n;
  endfunction

  function automatic logic [CALC_W-1:0] cnt_max(input int unsigned bits);
    return (bits >= CALC_W) ? '1 : ((CALC_W'(1) << bits) - CALC_W'(1));
  endfunction

  // Sum clamped to the largest value representable in 'bits' bits.
  function automatic logic [CALC_W-1:0] sat_add(input logic [CALC_W-1:0] a,
                                                input logic [CALC_W-1:0] b,
                                                input int unsigned       bits);
    logic [CALC_W:0] sum;
    logic [CALC_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = {1'b0, cnt_max(bits)};
    return (sum > lim) ? lim[CALC_W-1:0] : sum[CALC_W-1:0];
  endfunction

  function automatic logic sat_ovf(input logic [CALC_W-1:0] a,
                                   input logic [CALC_W-1:0] b,
                                   input int unsigned       bits);
    logic [CALC_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum > {1'b0, cnt_max(bits)};
  endfunction

endpackage

// File: rtl/msg_len_fifo.sv
// Synchronous show-ahead FIFO of length records; push while full is accepted
// only when a pop happens in the same cycle.
module msg_len_fifo
  import axis_msg_cnt_pkg::*;
#(
  parameter type         rec_t = len_rec_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  rec_t push_data,
  output logic full,
  input  logic pop,
  output rec_t pop_data,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  rec_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    pop_data = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/axis_msg_len_counter.sv
// Passive AXI4-Stream monitor: per-TDEST byte/beat accumulation, one length
// record per tlast beat, buffered for a valid/ready consumer.
module axis_msg_len_counter
  import axis_msg_cnt_pkg::*;
#(
  parameter int unsigned TKEEP_WIDTH    = 8,
  parameter int unsigned NUM_COUNT_BITS = 16,
  parameter int unsigned NUM_CHAN       = 4,
  parameter int unsigned CHAN_W         = ($clog2(NUM_CHAN) > 1) ? $clog2(NUM_CHAN) : 1,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_tvalid,
  input  logic                      s_tready,
  input  logic                      s_tlast,
  input  logic [TKEEP_WIDTH-1:0]    s_tkeep,
  input  logic [CHAN_W-1:0]         s_tdest,
  output logic                      m_len_valid,
  input  logic                      m_len_ready,
  output logic [NUM_COUNT_BITS-1:0] m_len_bytes,
  output logic [NUM_COUNT_BITS-1:0] m_len_beats,
  output logic [CHAN_W-1:0]         m_len_chan,
  output logic                      m_len_sat,
  output logic                      drop_pulse,
  output logic [NUM_COUNT_BITS-1:0] drop_count,
  output logic [NUM_CHAN-1:0]       busy
);

  typedef struct packed {
    logic [NUM_COUNT_BITS-1:0] bytes;
    logic [NUM_COUNT_BITS-1:0] beats;
    logic [CHAN_W-1:0]         chan;
    logic                      sat;
  } rec_t;

  localparam logic [NUM_COUNT_BITS-1:0] CNT_ONE = {{(NUM_COUNT_BITS-1){1'b0}}, 1'b1};

  logic [NUM_COUNT_BITS-1:0] acc_bytes [NUM_CHAN];
  logic [NUM_COUNT_BITS-1:0] acc_beats [NUM_CHAN];
  logic [NUM_CHAN-1:0]       acc_sat;

  logic              beat_ok;
  logic              in_range;
  logic [CHAN_W-1:0] ch;
  logic [CALC_W-1:0] pop_cnt;
  logic [CALC_W-1:0] cur_bytes;
  logic [CALC_W-1:0] cur_beats;
  logic              rec_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drop_now;
  rec_t              new_rec;
  rec_t              head_rec;

  // Out-of-range TDEST is steered to channel 0 for the (unused) lookup so the
  // accumulator arrays are never indexed past NUM_CHAN.
  always_comb begin
    beat_ok   = s_tvalid && s_tready;
    in_range  = CALC_W'(s_tdest) < CALC_W'(NUM_CHAN);
    ch        = in_range ? s_tdest : '0;
    pop_cnt   = popcount(KEEP_MAX_W'(s_tkeep));
    cur_bytes = CALC_W'(acc_bytes[ch]);
    cur_beats = CALC_W'(acc_beats[ch]);

    new_rec       = '0;
    new_rec.bytes = NUM_COUNT_BITS'(sat_add(cur_bytes, pop_cnt, NUM_COUNT_BITS));
    new_rec.beats = NUM_COUNT_BITS'(sat_add(cur_beats, CALC_W'(1), NUM_COUNT_BITS));
    new_rec.chan  = ch;
    new_rec.sat   = acc_sat[ch]
                  | sat_ovf(cur_bytes, pop_cnt, NUM_COUNT_BITS)
                  | sat_ovf(cur_beats, CALC_W'(1), NUM_COUNT_BITS);

    rec_push = beat_ok && in_range && s_tlast;
    fifo_pop = !fifo_empty && m_len_ready;
    drop_now = (rec_push && fifo_full && !fifo_pop) || (beat_ok && !in_range);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_CHAN; i++) begin
        acc_bytes[i] <= '0;
        acc_beats[i] <= '0;
      end
      acc_sat    <= '0;
      busy       <= '0;
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      drop_pulse <= drop_now;
      if (drop_now && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_ONE;
      end
      if (beat_ok && in_range) begin
        if (s_tlast) begin
          acc_bytes[ch] <= '0;
          acc_beats[ch] <= '0;
          acc_sat[ch]   <= 1'b0;
          busy[ch]      <= 1'b0;
        end else begin
          acc_bytes[ch] <= new_rec.bytes;
          acc_beats[ch] <= new_rec.beats;
          acc_sat[ch]   <= new_rec.sat;
          busy[ch]      <= 1'b1;
        end
      end
    end
  end

  msg_len_fifo #(
    .rec_t (rec_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rec_push),
    .push_data (new_rec),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .pop_data  (head_rec),
    .empty     (fifo_empty)
  );

  always_comb begin
    m_len_valid = !fifo_empty;
    m_len_bytes = head_rec.bytes;
    m_len_beats = head_rec.beats;
    m_len_chan  = head_rec.chan;
    m_len_sat   = head_rec.sat;
  end

endmodule
